// File: rtl/mdu_unit_if.sv
// Pipeline <-> MDU bundle: issue controls toward the unit,
// busy/occupied and the architectural HI/LO back to the pipeline.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        occupied;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, occupied, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, occupied, hi, lo
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy/occupied feed
// the hazard logic so it never has to model MDU latency.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   a_q, b_q;
    logic [1:0]    op_q;
    logic          busy_q;
    logic [31:0]   hi_q, lo_q;

    logic accept;
    assign accept = bus.start & ~bus.cancel & (state_q == IDLE)
                  & (bus.op <= 3'd5);

    assign bus.busy     = busy_q;
    assign bus.occupied = busy_q | (accept & ~bus.op[2]);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Zero and the MIN/-1 overflow case both divide by 1 instead:
    // zero is never written back, and MIN/1 already yields the
    // architected MIN quotient with a zero remainder.
    logic        b_zero, s_ovf;
    logic [31:0] sdiv, udiv;
    assign b_zero = (b_q == 32'd0);
    assign s_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign sdiv   = (b_zero | s_ovf) ? 32'd1 : b_q;
    assign udiv   = b_zero ? 32'd1 : b_q;

    logic signed [31:0] sa, sb, sq, sr;
    assign sa = a_q;
    assign sb = sdiv;
    assign sq = sa / sb;
    assign sr = sa % sb;

    logic [31:0] res_hi, res_lo;
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        unique case (op_q)
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            2'd2: begin
                res_hi = sr;
                res_lo = sq;
            end
            2'd3: begin
                res_hi = a_q % udiv;
                res_lo = a_q / udiv;
            end
        endcase
    end

    logic wr_en;
    assign wr_en = ~(op_q[1] & b_zero);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!bus.op[2]) begin
                            a_q     <= bus.a;
                            b_q     <= bus.b;
                            op_q    <= bus.op[1:0];
                            cnt_q   <= bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else if (bus.op[0]) begin
                            lo_q <= bus.a;
                        end else begin
                            hi_q <= bus.a;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (wr_en) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: expected HI/LO queued at issue,
// popped and compared when busy drops.
module tb_mdu_unit;
    logic clk;
    logic reset;
    mdu_if bus ();

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [63:0] sb[$];
    logic [63:0] mhl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] old);
        longint sa, sb2, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        p   = old;
        case (op)
            2'd0: p = sa * sb2;
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: if (b != 0) begin
                q = sa / sb2;
                r = sa % sb2;
                p = {r[31:0], q[31:0]};
            end
            default: if (b != 0) p = {a % b, a / b};
        endcase
        return p;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int n, input bit poke);
        logic [63:0] e;
        int c;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.a      = a;
        bus.b      = b;
        bus.cancel = 1'b0;
        #1 check("occ_start", 64'(bus.occupied), 64'd1);
        sb.push_back(exp);
        @(negedge clk);
        bus.start = poke;
        bus.op    = 3'd5;
        bus.a     = ~a;
        bus.b     = ~b;
        c = 0;
        while (bus.busy && c < 200) begin
            if (c == 0) check("hold", {bus.hi, bus.lo}, mhl);
            c++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy_len", 64'(c), 64'(n));
        e = sb.pop_front();
        check("hi", 64'(bus.hi), 64'(e[63:32]));
        check("lo", 64'(bus.lo), 64'(e[31:0]));
        mhl = e;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        mhl        = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_occ", 64'(bus.occupied), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, 1'b1);
        run_op(3'd3, 32'd7, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD, 10, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, 1'b0);

        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.a     = 32'h1234_5678;
        #1 check("mthi_occ", 64'(bus.occupied), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        mhl[63:32] = 32'h1234_5678;

        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.op     = 3'd0;
        bus.a      = 32'd9;
        bus.b      = 32'd9;
        #1 check("cancel_occ", 64'(bus.occupied), 64'd0);
        @(negedge clk);
        check("cancel_busy", 64'(bus.busy), 64'd0);
        check("cancel_hilo", {bus.hi, bus.lo}, mhl);
        bus.cancel = 1'b0;
        bus.op     = 3'd6;
        #1 check("rsvd_occ", 64'(bus.occupied), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("rsvd_busy", 64'(bus.busy), 64'd0);
        check("rsvd_hilo", {bus.hi, bus.lo}, mhl);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : $urandom;
            if (i == 6) rb = 32'd13;
            run_op(rop, ra, rb, model(rop[1:0], ra, rb, mhl), rop[1] ? 10 : 5, 1'b0);
        end

        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        mhl = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(3'd0, 32'd7, 32'd6, 64'd42, 5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1);
    end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Holds the architectural HI/LO registers.
- Produces the busy/occupied indication that the hazard-stall logic consumes, so the stall logic does not have to model MDU timing.
- Accepts one operation at a time.
- Results become visible on hi/lo only after the programmed latency completes.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  E-stage instruction is an MDU op this cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (ignored)
- a  input  32  forwarded rs value
- b  input  32  forwarded rt value
- cancel  input  1  exception/interrupt taken this cycle; suppresses start
- busy  output  1  operation in progress (registered)
- occupied  output  1  busy | accepted-start this cycle (combinational, to stall logic)
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset=0, any time, including mid-operation):
  - state=IDLE, busy=0, counter=0, hi=0, lo=0.
  - Pending result discarded.
- accept = start & ~cancel & (state==IDLE) & (op<=5). Reserved op values are never accepted.
- States: IDLE, RUN.
- IDLE, accept with op 0..3:
  - Latch a, b and op on the edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, accept with op 4/5:
  - Write a into hi (MTHI) or lo (MTLO) on that edge.
  - State stays IDLE; busy stays 0.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter==1: write the result to hi/lo, go to IDLE, busy=0.
  - busy is therefore high for exactly N cycles, with hi/lo updated on the edge ending the N-th cycle.
  - Inputs start/op/a/b/cancel are ignored in RUN. The stall logic guarantees no MDU instruction issues; any start seen here is dropped.
- occupied = busy | (accept & op<=3). It lets the stall logic hold an MFHI/MFLO or MDU op in D during the start cycle.
- Arithmetic:
  - MULT: {hi,lo} = signed(a) * signed(b), 64-bit.
  - MULTU: unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV overflow case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (b latched ==0): full latency still elapses; hi/lo are left unchanged.
- Result is computed from the latched operands. Later changes of a/b have no effect.
- hi/lo are readable at all times. During RUN they show the old values.
- cancel has no effect once RUN is entered; the operation completes. This is correct because the E-stage instruction that started it had already been accepted as committed.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3:
  - busy high for 5 cycles starting the cycle after start.
  - hi/lo unchanged until then.
  - Afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles; occupied=1 in the start cycle.
- DIV a=-7 (0xFFFFFFF9), b=2:
  - 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Repeat with DIVU 7/0 → hi/lo keep their prior values, busy still 10 cycles.
- MTHI a=0x12345678 → hi updated on the same edge, busy never asserts. A second start with MTLO issued during an ongoing DIV → ignored, lo unchanged by it.
- start=1, cancel=1, op=MULT → no busy, occupied=0, hi/lo unchanged. Then start=1, op=6 → ignored.
- Assert reset low at cycle 3 of a DIV → busy=0, hi=lo=0 immediately (asynchronous). After release, a new MULT runs normally.
